// File: rtl/frame_buf_wr.sv
// Frame capture writer: takes one armed frame of packed 32-bit words into a word-addressed RAM
// through a registered, stallable write port, and reports the byte length and overflow of that frame.
module frame_buf_wr #(
    parameter int ADDR_W    = 15,
    parameter int MAX_WORDS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_vld_i,
    output logic              s_rdy_o,
    input  logic [31:0]       s_data_i,
    input  logic              s_sof_i,
    input  logic              s_eof_i,
    input  logic [1:0]        s_be_i,
    output logic              mem_we_o,
    input  logic              mem_rdy_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_wmask_o,
    input  logic              arm_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ovf_o,
    output logic [ADDR_W+2:0] frame_bytes_o
);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} state_t;

    localparam logic [ADDR_W:0]   MAX_IDX   = (ADDR_W+1)'(MAX_WORDS);
    localparam logic [ADDR_W+2:0] MAX_BYTES = (ADDR_W+3)'(MAX_WORDS*4);
    localparam logic [ADDR_W:0]   IDX_ONE   = (ADDR_W+1)'(1);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          wmask_q, wmask_d;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [ADDR_W+2:0]   bytes_q, bytes_d;
    logic [ADDR_W+2:0]   frame_bytes_q, frame_bytes_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;

    logic                stall, accept, load;
    logic [ADDR_W:0]     load_idx;
    logic [2:0]          word_add;
    logic [3:0]          word_mask;

    function automatic logic [3:0] be_to_mask(input logic [1:0] be);
        case (be)
            2'd0:    be_to_mask = 4'b0001;
            2'd1:    be_to_mask = 4'b0011;
            2'd2:    be_to_mask = 4'b0111;
            default: be_to_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic [ADDR_W+2:0] sat_add(input logic [ADDR_W+2:0] a, input logic [2:0] b);
        logic [ADDR_W+3:0] s;
        s = {1'b0, a} + {{(ADDR_W+1){1'b0}}, b};
        sat_add = (s > {1'b0, MAX_BYTES}) ? MAX_BYTES : s[ADDR_W+2:0];
    endfunction

    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] i);
        sat_inc = (i < MAX_IDX) ? i + IDX_ONE : i;
    endfunction

    assign stall    = we_q & ~mem_rdy_i;
    assign s_rdy_o  = rst_n & (state_q != DONE) & ~stall;
    assign accept   = s_vld_i & s_rdy_o;
    assign word_add = s_eof_i ? ({1'b0, s_be_i} + 3'd1) : 3'd4;
    assign word_mask = s_eof_i ? be_to_mask(s_be_i) : 4'b1111;

    always_comb begin
        state_d       = state_q;
        we_d          = stall;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        idx_d         = idx_q;
        bytes_d       = bytes_q;
        frame_bytes_d = frame_bytes_q;
        done_d        = 1'b0;
        ovf_d         = ovf_q;
        load          = 1'b0;
        load_idx      = '0;

        case (state_q)
            IDLE: begin
                if (arm_i) begin
                    state_d = WAIT_SOF;
                    ovf_d   = 1'b0;
                end
            end
            WAIT_SOF, CAPTURE: begin
                // A sof word always (re)starts the frame at address 0, even mid-capture
                if (accept && s_sof_i) begin
                    load     = 1'b1;
                    load_idx = '0;
                    idx_d    = IDX_ONE;
                    bytes_d  = sat_add('0, word_add);
                    state_d  = s_eof_i ? DONE : CAPTURE;
                end else if (accept && state_q == CAPTURE) begin
                    load     = 1'b1;
                    load_idx = idx_q;
                    idx_d    = sat_inc(idx_q);
                    bytes_d  = sat_add(bytes_q, word_add);
                    if (s_eof_i) state_d = DONE;
                end
            end
            DONE: begin
                if (!stall) begin
                    done_d        = 1'b1;
                    frame_bytes_d = bytes_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            if (load_idx < MAX_IDX) begin
                we_d    = 1'b1;
                addr_d  = load_idx[ADDR_W-1:0];
                wdata_d = s_data_i;
                wmask_d = word_mask;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wmask_q       <= '0;
            idx_q         <= '0;
            bytes_q       <= '0;
            frame_bytes_q <= '0;
            done_q        <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wmask_q       <= wmask_d;
            idx_q         <= idx_d;
            bytes_q       <= bytes_d;
            frame_bytes_q <= frame_bytes_d;
            done_q        <= done_d;
            ovf_q         <= ovf_d;
        end
    end

    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign mem_wmask_o   = wmask_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign ovf_o         = ovf_q;
    assign frame_bytes_o = frame_bytes_q;

endmodule

// File: tb/tb_frame_buf_wr.sv
// Directed bench for frame_buf_wr with a 4-word frame RAM so overflow is reachable.
module tb_frame_buf_wr;

    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_vld;
    logic              s_rdy;
    logic [31:0]       s_data;
    logic              s_sof, s_eof;
    logic [1:0]        s_be;
    logic              mem_we;
    logic              mem_rdy;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic              arm;
    logic              busy, done, ovf;
    logic [ADDR_W+2:0] frame_bytes;

    int checks = 0;
    int fails  = 0;

    int          wr_n = 0;
    int          done_n = 0;
    int          we_cnt = 0;
    int          acc_n = 0;
    logic [ADDR_W-1:0] log_addr [64];
    logic [31:0]       log_data [64];
    logic [3:0]        log_mask [64];

    frame_buf_wr #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_vld_i(s_vld), .s_rdy_o(s_rdy), .s_data_i(s_data),
        .s_sof_i(s_sof), .s_eof_i(s_eof), .s_be_i(s_be),
        .mem_we_o(mem_we), .mem_rdy_i(mem_rdy), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
        .arm_i(arm), .busy_o(busy), .done_o(done), .ovf_o(ovf),
        .frame_bytes_o(frame_bytes)
    );

    always #5 clk = ~clk;

    // Record retired writes and done pulses as the RAM would see them
    always @(posedge clk) begin
        if (rst_n && mem_we && mem_rdy) begin
            log_addr[wr_n] <= mem_addr;
            log_data[wr_n] <= mem_wdata;
            log_mask[wr_n] <= mem_wmask;
            wr_n <= wr_n + 1;
        end
        if (done) done_n <= done_n + 1;
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1; cyc(); arm = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic sof, input logic eof, input logic [1:0] be);
        int n = 0;
        s_vld = 1'b1; s_data = d; s_sof = sof; s_eof = eof; s_be = be;
        #0;
        while (!s_rdy && n < 50) begin cyc(); n++; end
        if (n >= 50) begin
            checks++; fails++;
            $display("FAIL send_timeout: word %08h never accepted", d);
        end else begin
            acc_n++;
        end
        cyc();
        s_vld = 1'b0; s_sof = 1'b0; s_eof = 1'b0; s_be = 2'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cyc();
        checks++; if (s_rdy !== 1'b0) begin fails++; $display("FAIL rst_rdy: got %0b expected 0", s_rdy); end
        cyc(); cyc();
        checks++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_we: got %0b expected 0", mem_we); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0 || ovf !== 1'b0) begin fails++; $display("FAIL rst_done_ovf: got %0b%0b expected 00", done, ovf); end
        checks++; if (frame_bytes !== '0) begin fails++; $display("FAIL rst_bytes: got %0d expected 0", frame_bytes); end
        rst_n = 1'b1; #1;
        checks++; if (s_rdy !== 1'b1) begin fails++; $display("FAIL rst_rel_rdy: got %0b expected 1", s_rdy); end
    endtask

    task automatic test_basic();
        int w0 = wr_n; int d0 = done_n;
        pulse_arm();
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL t1_busy: got %0b expected 1", busy); end
        send(32'hA0A0_0001, 1, 0, 0);
        send(32'hA0A0_0002, 0, 0, 0);
        send(32'hA0A0_0003, 0, 1, 2);
        cyc(); cyc(); cyc();
        checks++; if (wr_n - w0 !== 3) begin fails++; $display("FAIL t1_nwr: got %0d expected 3", wr_n - w0); end
        checks++; if ({log_addr[w0], log_addr[w0+1], log_addr[w0+2]} !== 6'b00_01_10) begin fails++; $display("FAIL t1_addr: got %0d %0d %0d expected 0 1 2", log_addr[w0], log_addr[w0+1], log_addr[w0+2]); end
        checks++; if ({log_mask[w0], log_mask[w0+1], log_mask[w0+2]} !== 12'hFF7) begin fails++; $display("FAIL t1_mask: got %0h %0h %0h expected f f 7", log_mask[w0], log_mask[w0+1], log_mask[w0+2]); end
        checks++; if (log_data[w0+2] !== 32'hA0A0_0003) begin fails++; $display("FAIL t1_data: got %08h expected a0a00003", log_data[w0+2]); end
        checks++; if (done_n - d0 !== 1) begin fails++; $display("FAIL t1_done: got %0d pulses expected 1", done_n - d0); end
        checks++; if (frame_bytes !== 5'd11) begin fails++; $display("FAIL t1_bytes: got %0d expected 11", frame_bytes); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL t1_idle: got %0b expected 0", busy); end
    endtask

    task automatic test_unarmed();
        int e0 = we_cnt; int d0 = done_n; int a0 = acc_n;
        send(32'hB000_0000, 1, 0, 0);
        for (int i = 1; i < 4; i++) send(32'hB000_0000 + i, 0, 0, 0);
        send(32'hB000_0004, 0, 1, 3);
        cyc(); cyc();
        checks++; if (acc_n - a0 !== 5) begin fails++; $display("FAIL t2_acc: got %0d expected 5", acc_n - a0); end
        checks++; if (we_cnt - e0 !== 0) begin fails++; $display("FAIL t2_we: got %0d write cycles expected 0", we_cnt - e0); end
        checks++; if (done_n - d0 !== 0) begin fails++; $display("FAIL t2_done: got %0d expected 0", done_n - d0); end
    endtask

    task automatic test_stall();
        int w0 = wr_n; int d0 = done_n;
        pulse_arm();
        send(32'hC000_0000, 1, 0, 0);
        send(32'hC000_0001, 0, 0, 0);
        mem_rdy = 1'b0;
        s_vld = 1'b1; s_data = 32'hC000_0002; s_eof = 1'b1; s_be = 2'd3;
        #0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_rdy !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 2'd1 || mem_wdata !== 32'hC000_0001) begin
                fails++; $display("FAIL t3_hold%0d: rdy=%0b we=%0b addr=%0d data=%08h expected 0 1 1 c0000001", i, s_rdy, mem_we, mem_addr, mem_wdata);
            end
            if (i < 4) cyc();
        end
        mem_rdy = 1'b1; #0;
        checks++; if (s_rdy !== 1'b1) begin fails++; $display("FAIL t3_release: got %0b expected 1", s_rdy); end
        send(32'hC000_0002, 0, 1, 3);
        mem_rdy = 1'b0;
        cyc(); cyc();
        checks++; if (done_n - d0 !== 0 || busy !== 1'b1) begin fails++; $display("FAIL t3_early_done: done=%0d busy=%0b expected 0 1", done_n - d0, busy); end
        mem_rdy = 1'b1;
        cyc(); cyc(); cyc();
        checks++; if (wr_n - w0 !== 3) begin fails++; $display("FAIL t3_nwr: got %0d expected 3", wr_n - w0); end
        checks++; if (log_data[w0+1] !== 32'hC000_0001 || log_addr[w0+2] !== 2'd2 || log_mask[w0+2] !== 4'hF) begin fails++; $display("FAIL t3_log: data1=%08h addr2=%0d mask2=%0h expected c0000001 2 f", log_data[w0+1], log_addr[w0+2], log_mask[w0+2]); end
        checks++; if (done_n - d0 !== 1 || frame_bytes !== 5'd12) begin fails++; $display("FAIL t3_done: pulses=%0d bytes=%0d expected 1 12", done_n - d0, frame_bytes); end
    endtask

    task automatic test_overflow();
        int w0 = wr_n;
        pulse_arm();
        send(32'hD000_0000, 1, 0, 0);
        for (int i = 1; i < 5; i++) send(32'hD000_0000 + i, 0, 0, 0);
        send(32'hD000_0005, 0, 1, 0);
        cyc(); cyc(); cyc();
        checks++; if (wr_n - w0 !== 4) begin fails++; $display("FAIL t4_nwr: got %0d expected 4", wr_n - w0); end
        checks++; if (log_addr[w0+3] !== 2'd3 || log_data[w0+3] !== 32'hD000_0003) begin fails++; $display("FAIL t4_last: addr=%0d data=%08h expected 3 d0000003", log_addr[w0+3], log_data[w0+3]); end
        checks++; if (ovf !== 1'b1) begin fails++; $display("FAIL t4_ovf: got %0b expected 1", ovf); end
        checks++; if (frame_bytes !== 5'd16) begin fails++; $display("FAIL t4_bytes: got %0d expected 16", frame_bytes); end
        pulse_arm();
        checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL t4_ovf_clr: got %0b expected 0", ovf); end
    endtask

    task automatic test_restart();
        int w0 = wr_n; int d0 = done_n;
        send(32'hE000_0000, 1, 0, 0);
        send(32'hE000_0001, 0, 0, 0);
        send(32'hE000_0002, 1, 0, 0);
        send(32'hE000_0003, 0, 1, 3);
        cyc(); cyc(); cyc();
        checks++; if (wr_n - w0 !== 4) begin fails++; $display("FAIL t5_nwr: got %0d expected 4", wr_n - w0); end
        checks++; if ({log_addr[w0+2], log_addr[w0+3]} !== 4'b00_01 || log_data[w0+2] !== 32'hE000_0002) begin fails++; $display("FAIL t5_addr: got %0d %0d data=%08h expected 0 1 e0000002", log_addr[w0+2], log_addr[w0+3], log_data[w0+2]); end
        checks++; if (done_n - d0 !== 1 || frame_bytes !== 5'd8) begin fails++; $display("FAIL t5_done: pulses=%0d bytes=%0d expected 1 8", done_n - d0, frame_bytes); end
    endtask

    task automatic test_midframe_reset();
        pulse_arm();
        send(32'hF000_0000, 1, 0, 0);
        for (int i = 1; i < 5; i++) send(32'hF000_0000 + i, 0, 0, 0);
        send(32'hF000_0005, 1, 0, 0);
        mem_rdy = 1'b0;
        cyc();
        checks++; if (mem_we !== 1'b1 || ovf !== 1'b1 || mem_addr !== 2'd0) begin fails++; $display("FAIL t6_pre: we=%0b ovf=%0b addr=%0d expected 1 1 0", mem_we, ovf, mem_addr); end
        rst_n = 1'b0;
        cyc();
        checks++; if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL t6_ctl: we=%0b busy=%0b done=%0b expected 0 0 0", mem_we, busy, done); end
        checks++; if (ovf !== 1'b0 || frame_bytes !== '0) begin fails++; $display("FAIL t6_stat: ovf=%0b bytes=%0d expected 0 0", ovf, frame_bytes); end
        rst_n = 1'b1; mem_rdy = 1'b1; #1;
        checks++; if (s_rdy !== 1'b1) begin fails++; $display("FAIL t6_rdy: got %0b expected 1", s_rdy); end
    endtask

    initial begin
        rst_n = 1'b0; s_vld = 1'b0; s_data = '0; s_sof = 1'b0; s_eof = 1'b0;
        s_be = 2'd0; mem_rdy = 1'b1; arm = 1'b0;
        test_reset();
        test_basic();
        test_unarmed();
        test_stall();
        test_overflow();
        test_restart();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
